// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: streams host instruction words into instruction memory while holding the core in reset
module imem_load_ctrl #(
  parameter int IMEM_ADDR_WIDTH = 9,
  parameter int FLUSH_CYCLES    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       host_start,
  input  logic [IMEM_ADDR_WIDTH-1:0] host_base_addr,
  input  logic                       host_halt,
  input  logic                       host_run,
  input  logic                       host_wvalid,
  input  logic [31:0]                host_wdata,
  input  logic                       host_wlast,
  output logic                       host_wready,
  output logic                       host_busy,
  output logic                       host_done,
  output logic                       host_err,
  output logic [IMEM_ADDR_WIDTH:0]   words_loaded,
  output logic                       imem_prog_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_prog_addr,
  output logic [31:0]                imem_prog_wdata,
  output logic                       core_reset,
  output logic                       core_enable
);
  localparam int AW = IMEM_ADDR_WIDTH;
  localparam int FW = $clog2(FLUSH_CYCLES);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
  typedef enum logic [1:0] {HALT, LOAD, FLUSH, RUN} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d, err_q, err_d, done_q, done_d, accept;
  assign accept = host_wvalid && state_q == LOAD;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fcnt_d  = fcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      HALT, RUN: begin
        if (host_start) begin
          state_d = LOAD;
          ptr_d   = host_base_addr;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (state_q == HALT && host_run) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end else if (state_q == RUN && host_halt) begin
          state_d = HALT;
        end
      end
      LOAD: begin
        if (accept) begin
          if (cnt_q == DEPTH) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = host_wdata;
            ptr_d   = ptr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
          if (host_wlast) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end
      end
      default: begin
        state_d = fcnt_q == '0 ? RUN : FLUSH;
        done_d  = fcnt_q == '0;
        fcnt_d  = fcnt_q == '0 ? fcnt_q : fcnt_q - 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HALT;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end
  assign host_wready     = state_q == LOAD;
  assign host_busy       = state_q == LOAD || state_q == FLUSH;
  assign host_done       = done_q;
  assign host_err        = err_q;
  assign words_loaded    = cnt_q;
  assign imem_prog_we    = we_q;
  assign imem_prog_addr  = addr_q;
  assign imem_prog_wdata = wdata_q;
  assign core_reset      = state_q != RUN;
  assign core_enable     = state_q == RUN;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: directed scenario tests for imem_load_ctrl
module tb_imem_load_ctrl;
  logic        clk = 1'b0;
  logic        reset, host_start, host_halt, host_run, host_wvalid, host_wlast;
  logic [8:0]  host_base_addr;
  logic [31:0] host_wdata;
  logic        host_wready, host_busy, host_done, host_err, imem_prog_we, core_reset, core_enable;
  logic [9:0]  words_loaded;
  logic [8:0]  imem_prog_addr;
  logic [31:0] imem_prog_wdata;
  int n_cmp = 0;
  int n_fail = 0;

  imem_load_ctrl #(.IMEM_ADDR_WIDTH(9), .FLUSH_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .host_start(host_start), .host_base_addr(host_base_addr),
    .host_halt(host_halt), .host_run(host_run), .host_wvalid(host_wvalid),
    .host_wdata(host_wdata), .host_wlast(host_wlast), .host_wready(host_wready),
    .host_busy(host_busy), .host_done(host_done), .host_err(host_err),
    .words_loaded(words_loaded), .imem_prog_we(imem_prog_we),
    .imem_prog_addr(imem_prog_addr), .imem_prog_wdata(imem_prog_wdata),
    .core_reset(core_reset), .core_enable(core_enable)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string name, input logic exp_done);
    for (int i = 0; i < 20 && core_enable !== 1'b1; i++) cyc();
    n_cmp++;
    if (core_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_run_timeout: core_enable=%b want 1", name, core_enable);
    end
    n_cmp++;
    if (host_done !== exp_done) begin
      n_fail++;
      $display("FAIL %s_done: host_done=%b want %b", name, host_done, exp_done);
    end
  endtask

  task automatic start_load(input logic [8:0] base);
    host_start = 1'b1;
    host_base_addr = base;
    cyc();
    host_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    n_cmp++;
    if ({core_reset, core_enable, imem_prog_we, host_busy, host_wready, host_done, host_err} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_outputs: rst/en/we/busy/rdy/done/err=%b want 1000000",
               {core_reset, core_enable, imem_prog_we, host_busy, host_wready, host_done, host_err});
    end
    n_cmp++;
    if (words_loaded !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_words: words_loaded=%0d want 0", words_loaded);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    start_load(9'd0);
    n_cmp++;
    if ({host_wready, host_busy, core_reset} !== 3'b111) begin
      n_fail++;
      $display("FAIL basic_load_entry: rdy/busy/rst=%b want 111", {host_wready, host_busy, core_reset});
    end
    for (int i = 0; i < 3; i++) begin
      host_wvalid = 1'b1;
      host_wdata = d[i];
      host_wlast = i == 2;
      cyc();
      n_cmp++;
      if (imem_prog_we !== 1'b1 || imem_prog_addr !== 9'(i) || imem_prog_wdata !== d[i]) begin
        n_fail++;
        $display("FAIL basic_write%0d: we=%b addr=%0d data=%h want 1 %0d %h",
                 i, imem_prog_we, imem_prog_addr, imem_prog_wdata, i, d[i]);
      end
    end
    host_wvalid = 1'b0;
    host_wlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (core_reset !== 1'b1 || host_wready !== 1'b0 || host_done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_flush%0d: rst=%b rdy=%b done=%b want 1 0 0", i, core_reset, host_wready, host_done);
      end
      if (i > 0) begin
        n_cmp++;
        if (imem_prog_we !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_flush_we%0d: we=%b want 0", i, imem_prog_we);
        end
      end
      cyc();
    end
    n_cmp++;
    if ({core_reset, core_enable, host_done, host_busy} !== 4'b0110) begin
      n_fail++;
      $display("FAIL basic_run: rst/en/done/busy=%b want 0110", {core_reset, core_enable, host_done, host_busy});
    end
    n_cmp++;
    if (words_loaded !== 10'd3) begin
      n_fail++;
      $display("FAIL basic_words: words_loaded=%0d want 3", words_loaded);
    end
    cyc();
    n_cmp++;
    if (host_done !== 1'b0 || core_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b en=%b want 0 1", host_done, core_enable);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] ea [4] = '{9'd510, 9'd511, 9'd0, 9'd1};
    start_load(9'd510);
    for (int i = 0; i < 4; i++) begin
      host_wvalid = 1'b1;
      host_wdata = 32'h100 + 32'(i);
      host_wlast = i == 3;
      cyc();
      n_cmp++;
      if (imem_prog_we !== 1'b1 || imem_prog_addr !== ea[i] || imem_prog_wdata !== 32'h100 + 32'(i)) begin
        n_fail++;
        $display("FAIL wrap_write%0d: we=%b addr=%0d data=%h want 1 %0d %h",
                 i, imem_prog_we, imem_prog_addr, imem_prog_wdata, ea[i], 32'h100 + 32'(i));
      end
    end
    host_wvalid = 1'b0;
    host_wlast = 1'b0;
    wait_run("wrap", 1'b1);
    n_cmp++;
    if (host_err !== 1'b0 || words_loaded !== 10'd4) begin
      n_fail++;
      $display("FAIL wrap_status: err=%b words=%0d want 0 4", host_err, words_loaded);
    end
  endtask

  task automatic test_overflow();
    int writes = 0;
    int bad = 0;
    start_load(9'd0);
    for (int i = 0; i < 513; i++) begin
      host_wvalid = 1'b1;
      host_wdata = 32'hD000_0000 + 32'(i);
      host_wlast = i == 512;
      cyc();
      if (imem_prog_we === 1'b1) writes++;
      if (i < 512 && (imem_prog_we !== 1'b1 || imem_prog_addr !== 9'(i) || imem_prog_wdata !== 32'hD000_0000 + 32'(i))) bad++;
      if (i == 511 && host_err !== 1'b0) bad++;
    end
    host_wvalid = 1'b0;
    host_wlast = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ovf_sequence: %0d bad write cycles want 0", bad);
    end
    n_cmp++;
    if (writes != 512) begin
      n_fail++;
      $display("FAIL ovf_write_count: %0d writes want 512", writes);
    end
    n_cmp++;
    if (imem_prog_we !== 1'b0 || host_err !== 1'b1 || words_loaded !== 10'd512) begin
      n_fail++;
      $display("FAIL ovf_drop: we=%b err=%b words=%0d want 0 1 512", imem_prog_we, host_err, words_loaded);
    end
    wait_run("ovf", 1'b1);
    n_cmp++;
    if (host_err !== 1'b1 || words_loaded !== 10'd512) begin
      n_fail++;
      $display("FAIL ovf_sticky: err=%b words=%0d want 1 512", host_err, words_loaded);
    end
  endtask

  task automatic test_halt_run();
    host_halt = 1'b1;
    cyc();
    host_halt = 1'b0;
    n_cmp++;
    if ({core_reset, core_enable, host_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL halt: rst/en/busy=%b want 100", {core_reset, core_enable, host_busy});
    end
    host_run = 1'b1;
    cyc();
    host_run = 1'b0;
    n_cmp++;
    if ({host_busy, host_wready, imem_prog_we, core_reset} !== 4'b1001) begin
      n_fail++;
      $display("FAIL run_flush: busy/rdy/we/rst=%b want 1001", {host_busy, host_wready, imem_prog_we, core_reset});
    end
    wait_run("resume", 1'b1);
    n_cmp++;
    if (words_loaded !== 10'd512 || host_err !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_hold: words=%0d err=%b want 512 1", words_loaded, host_err);
    end
  endtask

  task automatic test_gap();
    start_load(9'd5);
    n_cmp++;
    if (host_err !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_err_clear: err=%b want 0", host_err);
    end
    host_wvalid = 1'b1;
    host_wdata = 32'h1234_5678;
    cyc();
    n_cmp++;
    if (imem_prog_we !== 1'b1 || imem_prog_addr !== 9'd5 || imem_prog_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL gap_w0: we=%b addr=%0d data=%h want 1 5 12345678", imem_prog_we, imem_prog_addr, imem_prog_wdata);
    end
    host_wvalid = 1'b0;
    cyc();
    n_cmp++;
    if (imem_prog_we !== 1'b0 || host_wready !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_idle: we=%b rdy=%b want 0 1", imem_prog_we, host_wready);
    end
    host_wvalid = 1'b1;
    host_wlast = 1'b1;
    host_wdata = 32'h9ABC_DEF0;
    cyc();
    host_wvalid = 1'b0;
    host_wlast = 1'b0;
    n_cmp++;
    if (imem_prog_we !== 1'b1 || imem_prog_addr !== 9'd6 || imem_prog_wdata !== 32'h9ABC_DEF0) begin
      n_fail++;
      $display("FAIL gap_w1: we=%b addr=%0d data=%h want 1 6 9abcdef0", imem_prog_we, imem_prog_addr, imem_prog_wdata);
    end
    wait_run("gap", 1'b1);
    n_cmp++;
    if (words_loaded !== 10'd2) begin
      n_fail++;
      $display("FAIL gap_words: words_loaded=%0d want 2", words_loaded);
    end
  endtask

  task automatic test_start_halt();
    host_start = 1'b1;
    host_halt = 1'b1;
    host_base_addr = 9'd0;
    cyc();
    host_start = 1'b0;
    host_halt = 1'b0;
    n_cmp++;
    if ({core_reset, host_busy, host_wready, core_enable} !== 4'b1110) begin
      n_fail++;
      $display("FAIL start_beats_halt: rst/busy/rdy/en=%b want 1110", {core_reset, host_busy, host_wready, core_enable});
    end
    n_cmp++;
    if (words_loaded !== 10'd0) begin
      n_fail++;
      $display("FAIL start_clears_cnt: words_loaded=%0d want 0", words_loaded);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      host_wvalid = 1'b1;
      host_wdata = 32'hE0 + 32'(i);
      cyc();
    end
    n_cmp++;
    if (imem_prog_we !== 1'b1 || imem_prog_addr !== 9'd1 || words_loaded !== 10'd2) begin
      n_fail++;
      $display("FAIL mid_pre: we=%b addr=%0d words=%0d want 1 1 2", imem_prog_we, imem_prog_addr, words_loaded);
    end
    host_wdata = 32'hE2;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    host_wvalid = 1'b0;
    n_cmp++;
    if ({imem_prog_we, core_reset, host_busy, host_wready} !== 4'b0100 || words_loaded !== 10'd0) begin
      n_fail++;
      $display("FAIL mid_reset: we/rst/busy/rdy=%b words=%0d want 0100 0",
               {imem_prog_we, core_reset, host_busy, host_wready}, words_loaded);
    end
    cyc();
    n_cmp++;
    if (imem_prog_we !== 1'b0 || host_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_write: we=%b busy=%b want 0 0", imem_prog_we, host_busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    host_start = 1'b0;
    host_halt = 1'b0;
    host_run = 1'b0;
    host_wvalid = 1'b0;
    host_wlast = 1'b0;
    host_base_addr = '0;
    host_wdata = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_halt_run();
    test_gap();
    test_start_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
